// File: rtl/mgmt_gpio_bank_if.sv
// Register bus between the management core and the GPIO bank.
// Writes and reads are single-cycle strobes. Read data comes back
// registered, one cycle after the read strobe, together with a
// one-cycle valid pulse.
interface mgmt_gpio_bank_if;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    // Core side: issues strobes and collects read data
    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        output bus_re,
        input  bus_rdata,
        input  bus_rvalid
    );

    // Bank side: decodes strobes and returns read data
    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        input  bus_re,
        output bus_rdata,
        output bus_rvalid
    );
endinterface

// File: rtl/mgmt_gpio_bank.sv
// mgmt_gpio_bank: CHANNELS bidirectional management GPIO lines on the
// simple register bus. Each line has an output value, an output enable
// and a synchronised input. A shared prescaler drives a blink phase
// that any line can select instead of its static output value.
//
// Optional feature macro: MGMT_GPIO_IRQ_EN
//   defined   - per-line edge interrupts (IRQ_EN, IRQ_EDGE, IRQ_STAT,
//               input history flop, irq output)
//   undefined - addresses 5..7 read 0 and ignore writes, irq tied 0,
//               no edge logic is built
//
// Register map (word address):
//   0 OUT  1 OE  2 IN (RO)  3 BLINK_EN  4 BLINK_PERIOD
//   5 IRQ_EN  6 IRQ_EDGE  7 IRQ_STAT (RO, write-1-to-clear)
module mgmt_gpio_bank #(
    parameter int CHANNELS = 8,
    parameter int BLINK_W  = 16
) (
    input  logic                core_clk,
    input  logic                core_rst,
    mgmt_gpio_bank_if.slave     bus,
    input  logic [CHANNELS-1:0] gpio_in,
    output logic [CHANNELS-1:0] gpio_out,
    output logic [CHANNELS-1:0] gpio_oeb,
    output logic                irq
);

    localparam logic [2:0] A_OUT   = 3'd0;
    localparam logic [2:0] A_OE    = 3'd1;
    localparam logic [2:0] A_IN    = 3'd2;
    localparam logic [2:0] A_BLEN  = 3'd3;
    localparam logic [2:0] A_BPER  = 3'd4;
    localparam logic [2:0] A_IEN   = 3'd5;
    localparam logic [2:0] A_IEDGE = 3'd6;
    localparam logic [2:0] A_ISTAT = 3'd7;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic                wr_out, wr_oe, wr_blen, wr_bper;
    logic [CHANNELS-1:0] wdata_ch;
    logic [BLINK_W-1:0]  wdata_per;

    assign wr_out    = bus.bus_we && (bus.bus_addr == A_OUT);
    assign wr_oe     = bus.bus_we && (bus.bus_addr == A_OE);
    assign wr_blen   = bus.bus_we && (bus.bus_addr == A_BLEN);
    assign wr_bper   = bus.bus_we && (bus.bus_addr == A_BPER);
    assign wdata_ch  = bus.bus_wdata[CHANNELS-1:0];
    assign wdata_per = bus.bus_wdata[BLINK_W-1:0];

    // Bits above CHANNELS / BLINK_W are dropped on purpose.
    logic unused_wdata;
    assign unused_wdata = ^bus.bus_wdata;

    // ------------------------------------------------------------------
    // Output / enable / blink-select registers
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] oe_q, oe_d;
    logic [CHANNELS-1:0] blen_q, blen_d;

    // Next-state for the plain RW channel registers
    always_comb begin
        out_d  = wr_out  ? wdata_ch : out_q;
        oe_d   = wr_oe   ? wdata_ch : oe_q;
        blen_d = wr_blen ? wdata_ch : blen_q;
    end

    // Channel register state
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            out_q  <= '0;
            oe_q   <= '0;
            blen_q <= '0;
        end else begin
            out_q  <= out_d;
            oe_q   <= oe_d;
            blen_q <= blen_d;
        end
    end

    // ------------------------------------------------------------------
    // Blink generator: cnt runs 0..period, phase toggles on the wrap,
    // so the phase holds for period+1 cycles. Writing the period
    // restarts the pattern from a known point (cnt 0, phase low).
    // ------------------------------------------------------------------
    logic [BLINK_W-1:0] per_q, per_d;
    logic [BLINK_W-1:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;

    // Next-state for period, prescaler and phase
    always_comb begin
        per_d   = per_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr_bper) begin
            per_d   = wdata_per;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == per_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + BLINK_W'(1);
        end
    end

    // Blink state
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            per_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser: s1 catches the async pad, s2 is the clean
    // value software reads as IN.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] s1_q, s2_q;

    // Two-flop synchroniser
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= gpio_in;
            s2_q <= s1_q;
        end
    end

`ifdef MGMT_GPIO_IRQ_EN
    // ------------------------------------------------------------------
    // Edge interrupts. s3 holds the previous synchronised value; an
    // edge of the selected polarity latches the status bit whether or
    // not the line is enabled, so software can poll masked lines.
    // A new edge beats a simultaneous write-1-to-clear.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] s3_q;
    logic [CHANNELS-1:0] ien_q, ien_d;
    logic [CHANNELS-1:0] iedge_q, iedge_d;
    logic [CHANNELS-1:0] stat_q, stat_d;
    logic [CHANNELS-1:0] rise, fall, edge_hit, w1c;

    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign edge_hit = (iedge_q & fall) | (~iedge_q & rise);
    assign w1c      = (bus.bus_we && (bus.bus_addr == A_ISTAT)) ? wdata_ch : '0;

    // Next-state for interrupt control and status
    always_comb begin
        ien_d   = (bus.bus_we && (bus.bus_addr == A_IEN))   ? wdata_ch : ien_q;
        iedge_d = (bus.bus_we && (bus.bus_addr == A_IEDGE)) ? wdata_ch : iedge_q;
        stat_d  = (stat_q & ~w1c) | edge_hit;
    end

    // Interrupt state and input history
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            s3_q    <= '0;
            ien_q   <= '0;
            iedge_q <= '0;
            stat_q  <= '0;
        end else begin
            s3_q    <= s2_q;
            ien_q   <= ien_d;
            iedge_q <= iedge_d;
            stat_q  <= stat_d;
        end
    end

    assign irq = |(stat_q & ien_q);
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path: data is taken from the current register values, so a
    // read that coincides with a write returns the old contents.
    // ------------------------------------------------------------------
    logic [31:0] rd_val;
    logic [31:0] rdata_q;
    logic        rvalid_q;

    // Read mux, unused upper bits are zero
    always_comb begin
        rd_val = '0;
        case (bus.bus_addr)
            A_OUT:   rd_val = 32'(out_q);
            A_OE:    rd_val = 32'(oe_q);
            A_IN:    rd_val = 32'(s2_q);
            A_BLEN:  rd_val = 32'(blen_q);
            A_BPER:  rd_val = 32'(per_q);
`ifdef MGMT_GPIO_IRQ_EN
            A_IEN:   rd_val = 32'(ien_q);
            A_IEDGE: rd_val = 32'(iedge_q);
            A_ISTAT: rd_val = 32'(stat_q);
`endif
            default: rd_val = '0;
        endcase
    end

    // Registered read data (held until the next read) and valid pulse
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus.bus_re;
            if (bus.bus_re)
                rdata_q <= rd_val;
        end
    end

    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;

    // ------------------------------------------------------------------
    // Pad drive
    // ------------------------------------------------------------------
    assign gpio_out = (blen_q & {CHANNELS{phase_q}}) | (out_q & ~blen_q);
    assign gpio_oeb = ~oe_q;

endmodule

// File: tb/tb_mgmt_gpio_bank.sv
// Self-checking bench for mgmt_gpio_bank (CHANNELS=8, BLINK_W=16).
// A cycle-level behavioural model predicts every output; a compare
// process checks it each negedge. Directed literal checks pin the model.
module tb_mgmt_gpio_bank;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gin;
    logic [7:0] gout, goeb;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    mgmt_gpio_bank_if bus ();

    mgmt_gpio_bank #(.CHANNELS(8), .BLINK_W(16)) dut (
        .core_clk (clk),
        .core_rst (rst),
        .bus      (bus),
        .gpio_in  (gin),
        .gpio_out (gout),
        .gpio_oeb (goeb),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;          // index of the most recent posedge
    logic [7:0]  samp [0:MAXC-1];  // pad value sampled at each edge (0 in reset)
    logic [7:0]  m_out, m_oe, m_blen, m_ien, m_iedge, m_stat;
    int          m_per, m_wedge;
    logic [31:0] m_rdata;
    logic        m_rvalid;

    function automatic logic [7:0] sampled(input int j);
        if (j < 0 || j >= MAXC) return 8'h00;
        return samp[j];
    endfunction

    // register value as software sees it just before edge cyc
    function automatic logic [31:0] mread(input logic [2:0] a);
        case (a)
            3'd0: return {24'h0, m_out};
            3'd1: return {24'h0, m_oe};
            3'd2: return {24'h0, sampled(cyc - 2)};
            3'd3: return {24'h0, m_blen};
            3'd4: return 32'(m_per);
`ifdef MGMT_GPIO_IRQ_EN
            3'd5: return {24'h0, m_ien};
            3'd6: return {24'h0, m_iedge};
            3'd7: return {24'h0, m_stat};
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [7:0] a, b, ev, clr;
        cyc++;
        if (rst) begin
            if (cyc < MAXC) samp[cyc] = 8'h00;
            m_out = 0; m_oe = 0; m_blen = 0; m_ien = 0; m_iedge = 0; m_stat = 0;
            m_per = 0; m_wedge = cyc; m_rdata = 0; m_rvalid = 0;
        end else begin
            if (cyc < MAXC) samp[cyc] = gin;
            m_rvalid = bus.bus_re;
            if (bus.bus_re) m_rdata = mread(bus.bus_addr);
`ifdef MGMT_GPIO_IRQ_EN
            // synchronised value at this edge is the pad two edges back;
            // the previous one is three edges back
            a   = sampled(cyc - 2);
            b   = sampled(cyc - 3);
            ev  = (m_iedge & ~a & b) | (~m_iedge & a & ~b);
            clr = (bus.bus_we && bus.bus_addr == 3'd7) ? bus.bus_wdata[7:0] : 8'h00;
            m_stat = (m_stat & ~clr) | ev;
`endif
            if (bus.bus_we) begin
                case (bus.bus_addr)
                    3'd0: m_out  = bus.bus_wdata[7:0];
                    3'd1: m_oe   = bus.bus_wdata[7:0];
                    3'd3: m_blen = bus.bus_wdata[7:0];
                    3'd4: begin m_per = int'(bus.bus_wdata[15:0]); m_wedge = cyc; end
`ifdef MGMT_GPIO_IRQ_EN
                    3'd5: m_ien   = bus.bus_wdata[7:0];
                    3'd6: m_iedge = bus.bus_wdata[7:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic       ph;
        logic [7:0] eo;
        if (cyc >= 1) begin
            ph = (((cyc - m_wedge) / (m_per + 1)) % 2) == 1;
            eo = (m_blen & {8{ph}}) | (m_out & ~m_blen);
            check("gpio_out", {24'h0, gout}, {24'h0, eo});
            check("gpio_oeb", {24'h0, goeb}, {24'h0, ~m_oe});
            check("irq", {31'h0, irq}, {31'h0, |(m_stat & m_ien)});
            check("rvalid", {31'h0, bus.bus_rvalid}, {31'h0, m_rvalid});
            check("rdata", bus.bus_rdata, m_rdata);
        end
    end

    // ---------------- bus helpers (called at a negedge) ----------------
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.bus_we = 1'b1; bus.bus_addr = a; bus.bus_wdata = d;
        @(negedge clk);
        bus.bus_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.bus_re = 1'b1; bus.bus_addr = a;
        @(negedge clk);
        bus.bus_re = 1'b0;
        d = bus.bus_rdata;
    endtask

    initial begin
        logic [31:0] d, d0;
        logic        prev;
        int          tog;
        logic [7:0]  others;

        rst = 1'b1; gin = 8'h00;
        bus.bus_we = 0; bus.bus_re = 0; bus.bus_addr = 0; bus.bus_wdata = 0;
        repeat (5) @(negedge clk);
        check("rst_gpio_out", {24'h0, gout}, 32'h0);
        check("rst_gpio_oeb", {24'h0, goeb}, 32'hFF);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rvalid", {31'h0, bus.bus_rvalid}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            check("rst_read", d, 32'h0);
        end

        // static output
        wr(3'd1, 32'h0F);
        wr(3'd0, 32'hA5);
        check("static_oeb", {24'h0, goeb}, 32'hF0);
        check("static_out", {24'h0, gout}, 32'hA5);
        rd(3'd0, d);
        check("read_out", d, 32'hA5);
        wr(3'd1, 32'hFFFF_FF3C);
        rd(3'd1, d);
        check("read_oe_masked", d, 32'h3C);

        // blink: period 3 -> 20 toggles in 80 cycles on bit 0 only
        wr(3'd0, 32'h0);
        wr(3'd4, 32'h3);
        wr(3'd3, 32'h1);
        prev = gout[0]; tog = 0; others = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (gout[0] != prev) tog++;
            prev = gout[0];
            others |= gout & 8'hFE;
        end
        check("blink_toggles", 32'(tog), 32'd20);
        check("blink_others", {24'h0, others}, 32'h0);
        wr(3'd3, 32'h0);

        // input sync
        gin = 8'h3C;
        rd(3'd2, d0);
        check("in_sync_k", d0, 32'h00);
        rd(3'd2, d);
        rd(3'd2, d);
        check("in_sync_k2", d, 32'h3C);

`ifdef MGMT_GPIO_IRQ_EN
        gin = 8'h02;
        repeat (4) @(negedge clk);
        wr(3'd7, 32'hFF);
        wr(3'd5, 32'h02);
        wr(3'd6, 32'h02);
        check("irq_idle", {31'h0, irq}, 32'h0);
        gin = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("irq_k1", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("irq_k2", {31'h0, irq}, 32'h1);
        rd(3'd7, d);
        check("irq_stat", d & 32'h2, 32'h2);
        wr(3'd7, 32'h02);
        check("irq_w1c", {31'h0, irq}, 32'h0);
        gin = 8'h02;
        repeat (4) @(negedge clk);
        wr(3'd7, 32'hFF);
        gin = 8'h00;
        @(negedge clk);
        @(negedge clk);
        wr(3'd7, 32'h02);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        wr(3'd7, 32'h02);
        check("irq_clear2", {31'h0, irq}, 32'h0);
`else
        for (int i = 0; i < 6; i++) begin
            gin = ~gin;
            repeat (3) @(negedge clk);
            check("noirq_irq", {31'h0, irq}, 32'h0);
        end
        wr(3'd5, 32'hFF);
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'hFF);
        for (int i = 5; i < 8; i++) begin
            rd(3'(i), d);
            check("noirq_read", d, 32'h0);
        end
`endif

        // randomized traffic, one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) gin = 8'($urandom);
            bus.bus_addr  = 3'($urandom_range(0, 7));
            bus.bus_we    = ($urandom_range(0, 2) == 0);
            bus.bus_re    = ($urandom_range(0, 1) == 0);
            bus.bus_wdata = (bus.bus_addr == 3'd4) ? 32'($urandom_range(0, 6)) | (32'($urandom) & 32'hFFFF_0000)
                                                   : $urandom;
            rst = (i >= 700 && i < 706);
            @(negedge clk);
        end
        bus.bus_we = 0; bus.bus_re = 0; rst = 0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
